gray_step_monitor: RTL and testbench
====================================

Name: gray_step_monitor

Overview:
- Sits directly downstream of the 2-digit (8-bit) Gray up/down counter and consumes its `gray`, `en`, `dir` (and optionally `cout`) outputs.
- Decodes the per-nibble Gray code to binary and tracks the expected count.
- Flags any illegal step (skipped, repeated or wrong-direction code), counts errors, pulses on wrap-around, and resynchronises after errors.
- Serves as the on-chip checker/observer for the counter stage.

Parameters:
- DIGITS, 2, number of 4-bit Gray digits in the input word; input width = 4*DIGITS.
- ERR_CNT_W, 8, width of the saturating error counter.
- RESYNC_GOOD, 4, consecutive legal steps required to leave RESYNC (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- gray  in  4*DIGITS  digit-wise Gray code from the counter; digit d occupies bits [4d+3:4d].
- en  in  1  counter enable, as driven to the counter.
- dir  in  1  counter direction: 1 = up, 0 = down.
- cout  in  1  counter carry/borrow flag; used only with GRAY_MON_COUT_CHECK_EN.
- bin  out  4*DIGITS  registered binary value of the last sampled `gray`.
- state  out  2  FSM state: 0 IDLE, 1 TRACK, 2 RESYNC.
- step_err  out  1  one-cycle pulse on an illegal step.
- wrap  out  1  one-cycle pulse on a legal max->0 (up) or 0->max (down) step in TRACK.
- err_cnt  out  ERR_CNT_W  saturating count of step_err pulses.

Behaviour:
- Reset (async, while rst=1) clears bin, step_err, wrap, err_cnt, the good-run counter, en_q and dir_q. state=IDLE.
- The counter updates on the falling clock edge; this block samples `gray` on the rising edge, half a cycle later.
- Decode: each digit is converted independently, b[3]=g[3], b[i]=b[i+1]^g[i]. The decoded digits are concatenated into `cur` (digit-wise, not reflected over the full word).
- en_q and dir_q are en and dir registered at the previous rising edge; they describe the step the counter took in between.
- Expected value: exp = en_q ? (dir_q ? bin+1 : bin-1) : bin, computed modulo 2^(4*DIGITS).
- IDLE: the first rising edge after reset release loads bin<=cur, goes to TRACK, and raises no error.
- TRACK, every cycle, bin<=cur:
  - If cur==exp: legal step. wrap=1 if en_q and (dir_q & bin==max | ~dir_q & bin==0).
  - Else: step_err=1, err_cnt+1 (saturates at all-ones), good-run counter<=0, go to RESYNC.
- RESYNC, every cycle, bin<=cur (reference reloaded from the observed value):
  - cur==exp increments the good-run counter; on reaching RESYNC_GOOD, clear it and go to TRACK.
  - A mismatch clears the good-run counter; no further step_err or err_cnt increment while in RESYNC.
  - wrap is suppressed in RESYNC.
- Outputs are registered: step_err and wrap assert in the cycle after the offending sample and last exactly one cycle.
- A dir change takes effect for the step after the edge that registers it. Simultaneous en=0 and dir change: no step is expected.
- Reset asserted mid-operation: immediate clear; err_cnt is not preserved.

Optional Feature:
- Macro GRAY_MON_COUT_CHECK_EN.
- Defined: in TRACK, the registered cout must equal (dir_q ? bin==max : bin==0) for the currently held bin. A mismatch is treated exactly as an illegal step (step_err, err_cnt, go to RESYNC).
- Undefined: the cout port is present but ignored, and no cout logic is generated.

Decomposition:
- Shared package gray_mon_pkg holds:
  - state encoding constants ST_IDLE=0, ST_TRACK=1, ST_RESYNC=2;
  - DIGIT_W=4;
  - the function computing max value from DIGITS.
- One sub-module, gray_digit_decode: 4-bit Gray in, 4-bit binary out, combinational. Instantiated DIGITS times with a generate loop.

Test Plan:
- Reset, then gray=0x00, en=1, dir=1 for 20 cycles, counter stepping 0x00,0x01,0x03,0x02,... -> state TRACK, bin counts 0..19 (0x0F->0x10 is gray 0x08->0x10), step_err never asserts.
- Up-count from bin 0xFE through 0xFF (gray 0x88) to 0x00 -> wrap pulses exactly one cycle, no step_err. Repeat the 0x01->0x00->0xFF pass with dir=0 -> wrap pulse.
- In TRACK at bin 0x05, force gray to the code for 0x07 (skip) -> step_err for one cycle, err_cnt=1, state RESYNC. Then 4 legal steps -> state TRACK on the 4th; a mismatch on the 2nd restarts the run.
- en=0 for 5 cycles with gray held at 0x23 -> no error. Gray changing while en_q=0 -> step_err.
- Inject 300 errors, allowing resync between each -> err_cnt saturates at 0xFF. Then assert rst mid-count -> all outputs 0, state IDLE asynchronously.
- With GRAY_MON_COUT_CHECK_EN: cout held 0 while bin=0xFF, dir=1 -> step_err. Without the macro, same stimulus -> no error.

Source files
------------

// File: rtl/gray_mon_pkg.sv
// Shared definitions for the Gray step monitor: FSM encoding, digit width
// and the full-scale count helper.
package gray_mon_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_RESYNC = 2'd2
   } state_e;

   // All-ones value of a DIGITS-digit word; 64-bit so wide configurations do not overflow.
   function automatic logic [63:0] gray_max(input int digits);
      return (64'd1 << (DIGIT_W * digits)) - 64'd1;
   endfunction

endpackage

// File: rtl/gray_digit_decode.sv
// Combinational 4-bit Gray-to-binary converter for a single counter digit.
module gray_digit_decode
   import gray_mon_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_gray,
   output logic [DIGIT_W-1:0] o_bin
);

   assign o_bin = {i_gray[3],
                   i_gray[3] ^ i_gray[2],
                   i_gray[3] ^ i_gray[2] ^ i_gray[1],
                   i_gray[3] ^ i_gray[2] ^ i_gray[1] ^ i_gray[0]};

endmodule

// File: rtl/gray_step_monitor.sv
// Observer for the digit-wise Gray up/down counter: flags illegal steps, counts
// errors, pulses on wrap and resynchronises. Optional GRAY_MON_COUT_CHECK_EN adds a carry check.
module gray_step_monitor
   import gray_mon_pkg::*;
#(
   parameter int DIGITS      = 2,
   parameter int ERR_CNT_W   = 8,
   parameter int RESYNC_GOOD = 4
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIGIT_W*DIGITS-1:0]     gray,
   input  logic                          en,
   input  logic                          dir,
   input  logic                          cout,
   output logic [DIGIT_W*DIGITS-1:0]     bin,
   output logic [1:0]                    state,
   output logic                          step_err,
   output logic                          wrap,
   output logic [ERR_CNT_W-1:0]          err_cnt
);

   localparam int                W   = DIGIT_W * DIGITS;
   localparam logic [W-1:0]      MAX = W'(gray_max(DIGITS));
   localparam logic [3:0]        GOOD_LAST = 4'(RESYNC_GOOD - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [W-1:0]         r_bin;
   logic [W-1:0]         w_cur;
   logic [W-1:0]         w_exp;
   logic                 r_en_q;
   logic                 r_dir_q;
   logic                 r_step_err;
   logic                 r_wrap;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic [3:0]           r_good;
   logic                 w_match;
   logic                 w_cout_bad;
   logic                 w_bad;
   logic                 w_at_end;
   logic                 w_step_err_d;
   logic                 w_wrap_d;
   logic [3:0]           w_good_d;

   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      gray_digit_decode u_dec (
         .i_gray (gray[DIGIT_W*d +: DIGIT_W]),
         .o_bin  (w_cur[DIGIT_W*d +: DIGIT_W])
      );
   end

   // Reference for this sample: the step the counter was told to take last cycle.
   assign w_exp    = r_en_q ? (r_dir_q ? r_bin + W'(1) : r_bin - W'(1)) : r_bin;
   assign w_match  = (w_cur == w_exp);
   assign w_at_end = r_dir_q ? (r_bin == MAX) : (r_bin == '0);

`ifdef GRAY_MON_COUT_CHECK_EN
   logic r_cout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cout_q <= 1'b0;
      else     r_cout_q <= cout;
   end

   assign w_cout_bad = (r_cout_q != w_at_end);
`else
   logic w_unused_cout;
   assign w_unused_cout = cout;
   assign w_cout_bad    = 1'b0;
`endif

   assign w_bad = ~w_match | w_cout_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   w_state_nxt = ST_TRACK;
         ST_TRACK:  if (w_bad) w_state_nxt = ST_RESYNC;
         ST_RESYNC: if (w_match && r_good == GOOD_LAST) w_state_nxt = ST_TRACK;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_step_err_d = 1'b0;
      w_wrap_d     = 1'b0;
      w_good_d     = 4'd0;
      case (r_state)
         ST_TRACK: begin
            w_step_err_d = w_bad;
            w_wrap_d     = ~w_bad & r_en_q & w_at_end;
         end
         ST_RESYNC: begin
            if (w_match && r_good != GOOD_LAST) w_good_d = r_good + 4'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin      <= '0;
         r_en_q     <= 1'b0;
         r_dir_q    <= 1'b0;
         r_step_err <= 1'b0;
         r_wrap     <= 1'b0;
         r_err_cnt  <= '0;
         r_good     <= 4'd0;
      end else begin
         r_bin      <= w_cur;
         r_en_q     <= en;
         r_dir_q    <= dir;
         r_step_err <= w_step_err_d;
         r_wrap     <= w_wrap_d;
         r_good     <= w_good_d;
         if (w_step_err_d && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign bin      = r_bin;
   assign state    = r_state;
   assign step_err = r_step_err;
   assign wrap     = r_wrap;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor: counting, wrap, skip/resync, hold,
// error saturation, async reset and the carry check.
module tb_gray_step_monitor;

   localparam int DIGITS      = 2;
   localparam int ERR_CNT_W   = 8;
   localparam int RESYNC_GOOD = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           gray;
   logic                 en;
   logic                 dir;
   logic                 cout;
   logic [7:0]           bin;
   logic [1:0]           state;
   logic                 step_err;
   logic                 wrap;
   logic [ERR_CNT_W-1:0] err_cnt;

   int n_vec = 0;
   int n_bad = 0;
   bit cout_zero = 1'b0;
   logic [7:0] v;

   gray_step_monitor #(
      .DIGITS      (DIGITS),
      .ERR_CNT_W   (ERR_CNT_W),
      .RESYNC_GOOD (RESYNC_GOOD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .gray     (gray),
      .en       (en),
      .dir      (dir),
      .cout     (cout),
      .bin      (bin),
      .state    (state),
      .step_err (step_err),
      .wrap     (wrap),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_gray(input logic [7:0] b);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = b[7:4];
      lo = b[3:0];
      return {hi ^ (hi >> 1), lo ^ (lo >> 1)};
   endfunction

   // Counter side: new code on the falling edge, monitor samples on the rising edge.
   task automatic drive(input logic [7:0] b, input logic e, input logic d);
      @(negedge clk);
      rst  = 1'b0;
      gray = to_gray(b);
      en   = e;
      dir  = d;
      cout = cout_zero ? 1'b0 : (d ? (b == 8'hFF) : (b == 8'h00));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      gray = 8'h00;
      en   = 1'b0;
      dir  = 1'b1;
      cout = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_state", state, 2'd0);
      check_val("rst_bin", bin, 8'h00);
      check_val("rst_err", step_err, 1'b0);
      check_val("rst_wrap", wrap, 1'b0);
      check_val("rst_cnt", err_cnt, 8'h00);

      // Plain up-count 0..19
      drive(8'h00, 1'b1, 1'b1);
      check_val("idle_state", state, 2'd1);
      check_val("idle_err", step_err, 1'b0);
      for (int i = 1; i < 20; i++) begin
         drive(8'(i), 1'b1, 1'b1);
         check_val("up_bin", bin, 8'(i));
         check_val("up_err", step_err, 1'b0);
      end
      check_val("up_state", state, 2'd1);

      // Wrap up through 0xFF, then reverse and wrap down
      do_reset();
      drive(8'hFD, 1'b1, 1'b1);
      drive(8'hFE, 1'b1, 1'b1);
      drive(8'hFF, 1'b1, 1'b1);
      check_val("wup_pre", wrap, 1'b0);
      drive(8'h00, 1'b1, 1'b1);
      check_val("wup_wrap", wrap, 1'b1);
      check_val("wup_err", step_err, 1'b0);
      drive(8'h01, 1'b1, 1'b1);
      check_val("wup_post", wrap, 1'b0);
      drive(8'h02, 1'b1, 1'b0);
      drive(8'h01, 1'b1, 1'b0);
      check_val("dn_bin", bin, 8'h01);
      drive(8'h00, 1'b1, 1'b0);
      check_val("wdn_pre", wrap, 1'b0);
      drive(8'hFF, 1'b1, 1'b0);
      check_val("wdn_wrap", wrap, 1'b1);
      check_val("wdn_bin", bin, 8'hFF);
      drive(8'hFE, 1'b1, 1'b0);
      check_val("wdn_post", wrap, 1'b0);
      check_val("wdn_err", err_cnt, 8'h00);

      // Skip 0x05 -> 0x07, then resync with a broken run
      do_reset();
      drive(8'h03, 1'b1, 1'b1);
      drive(8'h04, 1'b1, 1'b1);
      drive(8'h05, 1'b1, 1'b1);
      drive(8'h07, 1'b1, 1'b1);
      check_val("skip_err", step_err, 1'b1);
      check_val("skip_cnt", err_cnt, 8'h01);
      check_val("skip_state", state, 2'd2);
      drive(8'h08, 1'b1, 1'b1);
      check_val("rs1_err", step_err, 1'b0);
      check_val("rs1_state", state, 2'd2);
      drive(8'h20, 1'b1, 1'b1);
      check_val("rs2_err", step_err, 1'b0);
      check_val("rs2_cnt", err_cnt, 8'h01);
      drive(8'h21, 1'b1, 1'b1);
      drive(8'h22, 1'b1, 1'b1);
      drive(8'h23, 1'b1, 1'b1);
      check_val("rs_run3", state, 2'd2);
      drive(8'h24, 1'b1, 1'b1);
      check_val("rs_run4", state, 2'd1);
      check_val("rs_cnt", err_cnt, 8'h01);

      // Hold with en=0 at gray 0x23 (binary 0x32), dir toggling
      do_reset();
      drive(8'h31, 1'b1, 1'b1);
      drive(8'h32, 1'b0, 1'b1);
      check_val("hold_gray", gray, 8'h23);
      for (int i = 0; i < 5; i++) begin
         drive(8'h32, 1'b0, 1'(i));
         check_val("hold_err", step_err, 1'b0);
      end
      check_val("hold_state", state, 2'd1);
      drive(8'h33, 1'b0, 1'b1);
      check_val("hold_move_err", step_err, 1'b1);
      check_val("hold_move_cnt", err_cnt, 8'h01);

      // 300 errors with resync between each
      do_reset();
      v = 8'h00;
      drive(v, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         v = v + 8'd2;
         drive(v, 1'b1, 1'b1);
         if (i == 9) check_val("sat_10", err_cnt, 8'd10);
         for (int k = 0; k < RESYNC_GOOD; k++) begin
            v = v + 8'd1;
            drive(v, 1'b1, 1'b1);
         end
         if (i == 254) check_val("sat_255", err_cnt, 8'hFF);
      end
      check_val("sat_300", err_cnt, 8'hFF);
      check_val("sat_state", state, 2'd1);

      // Asynchronous reset mid-run
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("arst_state", state, 2'd0);
      check_val("arst_bin", bin, 8'h00);
      check_val("arst_cnt", err_cnt, 8'h00);
      check_val("arst_err", step_err, 1'b0);
      check_val("arst_wrap", wrap, 1'b0);

      // Carry held low at 0xFF counting up
      @(posedge clk);
      #1;
      drive(8'hFE, 1'b1, 1'b1);
      cout_zero = 1'b1;
      drive(8'hFF, 1'b1, 1'b1);
      cout_zero = 1'b0;
      drive(8'h00, 1'b1, 1'b1);
`ifdef GRAY_MON_COUT_CHECK_EN
      check_val("cout_err", step_err, 1'b1);
      check_val("cout_state", state, 2'd2);
      check_val("cout_wrap", wrap, 1'b0);
`else
      check_val("cout_err", step_err, 1'b0);
      check_val("cout_state", state, 2'd1);
      check_val("cout_wrap", wrap, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
